// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer
// Walks data bank entries 0..n_tx_end through the SPI master one byte at a
// time, writes each received byte back at the index just sent, then posts
// completion status to the control register.
// Optional build macro: SPI_SEQ_TIMEOUT_EN adds a WAIT_RX watchdog and an
// ABORT path that reports error=1 instead of waiting forever.
//
// state   | meaning
// IDLE    | waiting for ctrl_in.send
// LOAD    | bank_addr=index, two cycles so bank_rdata settles
// SEND    | wait for spi_tx_ready, launch one byte
// WAIT_RX | wait for the received byte (optionally time-limited)
// STORE   | write received byte back to bank[index]
// NEXT    | finish on last index, otherwise advance
// FINISH  | control register write-back issued, return to IDLE
// ABORT   | timeout write-back issued, return to IDLE (timeout build only)
module spi_txn_sequencer #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [15:0]       ctrl_in,
    output logic [15:0]       ctrl_out,
    output logic              ctrl_we,
    output logic [ADDR_W-1:0] bank_addr,
    input  logic [DATA_W-1:0] bank_rdata,
    output logic [DATA_W-1:0] bank_wdata,
    output logic              bank_we,
    output logic [DATA_W-1:0] spi_tx_byte,
    output logic              spi_tx_dv,
    input  logic              spi_tx_ready,
    input  logic              spi_rx_dv,
    input  logic [DATA_W-1:0] spi_rx_byte,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_RX,
        S_STORE,
        S_NEXT,
        S_FINISH
`ifdef SPI_SEQ_TIMEOUT_EN
        , S_ABORT
`endif
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] n_tx_end;
    logic              all_ones;
    logic              all_zeros;
    logic              load_wait;
    logic [15:0]       ctrl_done;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0]  tmr;
    logic [ADDR_W-1:0] last_done;
    logic [15:0]       ctrl_abort;

    // abort status: error set, n_rx = last byte fully stored (0 if none)
    always_comb begin
        last_done                = (index == '0) ? '0 : index - 1'b1;
        ctrl_abort               = ctrl_in;
        ctrl_abort[0]            = 1'b0;
        ctrl_abort[3]            = 1'b1;
        ctrl_abort[8 +: ADDR_W]  = last_done;
    end
`endif

    // completion status: send and error cleared, n_rx = last index stored
    always_comb begin
        ctrl_done               = ctrl_in;
        ctrl_done[0]            = 1'b0;
        ctrl_done[3]            = 1'b0;
        ctrl_done[8 +: ADDR_W]  = n_tx_end;
    end

    // sequencer FSM; all outputs registered, strobes default low each cycle
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            index       <= '0;
            n_tx_end    <= '0;
            all_ones    <= 1'b0;
            all_zeros   <= 1'b0;
            load_wait   <= 1'b0;
            ctrl_out    <= '0;
            ctrl_we     <= 1'b0;
            bank_addr   <= '0;
            bank_wdata  <= '0;
            bank_we     <= 1'b0;
            spi_tx_byte <= '0;
            spi_tx_dv   <= 1'b0;
            busy        <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
            tmr         <= '0;
`endif
        end else begin
            ctrl_we   <= 1'b0;
            bank_we   <= 1'b0;
            spi_tx_dv <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ctrl_in[0]) begin
                        n_tx_end  <= ctrl_in[4 +: ADDR_W];
                        all_ones  <= ctrl_in[1];
                        all_zeros <= ctrl_in[2];
                        index     <= '0;
                        bank_addr <= '0;
                        load_wait <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    load_wait <= 1'b1;
                    if (load_wait) begin
                        load_wait <= 1'b0;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (spi_tx_ready) begin
                        if (all_ones)
                            spi_tx_byte <= '1;
                        else if (all_zeros)
                            spi_tx_byte <= '0;
                        else
                            spi_tx_byte <= bank_rdata;
                        spi_tx_dv <= 1'b1;
`ifdef SPI_SEQ_TIMEOUT_EN
                        tmr       <= TMR_W'(TIMEOUT - 1);
`endif
                        state     <= S_WAIT_RX;
                    end
                end
                S_WAIT_RX: begin
                    if (spi_rx_dv) begin
                        bank_wdata <= spi_rx_byte;
                        bank_we    <= 1'b1;
                        state      <= S_STORE;
                    end
`ifdef SPI_SEQ_TIMEOUT_EN
                    else if (tmr == '0) begin
                        ctrl_out <= ctrl_abort;
                        ctrl_we  <= 1'b1;
                        state    <= S_ABORT;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
`endif
                end
                S_STORE: begin
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (index == n_tx_end) begin
                        ctrl_out <= ctrl_done;
                        ctrl_we  <= 1'b1;
                        state    <= S_FINISH;
                    end else begin
                        index     <= index + 1'b1;
                        bank_addr <= index + 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
`ifdef SPI_SEQ_TIMEOUT_EN
                S_ABORT: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// tb_spi_txn_sequencer
// Scoreboard bench: a bank model, a control-register model and a looped-back
// SPI responder surround the sequencer. Expected tx bytes, bank writes and
// control write-backs are queued when a burst is requested and popped as the
// DUT produces them. Define SPI_SEQ_TIMEOUT_EN to exercise the abort path.
module tb_spi_txn_sequencer;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TIMEOUT = 20;
`else
    localparam int TIMEOUT = 255;
`endif

    logic        clk_in = 1'b0;
    logic        rst    = 1'b0;
    logic [15:0] ctrl_in = '0;
    logic [15:0] ctrl_out;
    logic        ctrl_we;
    logic [3:0]  bank_addr;
    logic [7:0]  bank_rdata = '0;
    logic [7:0]  bank_wdata;
    logic        bank_we;
    logic [7:0]  spi_tx_byte;
    logic        spi_tx_dv;
    logic        spi_tx_ready;
    logic        spi_rx_dv;
    logic [7:0]  spi_rx_byte;
    logic        busy;

    spi_txn_sequencer #(.DATA_W(8), .ADDR_W(4), .TIMEOUT(TIMEOUT)) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .ctrl_in      (ctrl_in),
        .ctrl_out     (ctrl_out),
        .ctrl_we      (ctrl_we),
        .bank_addr    (bank_addr),
        .bank_rdata   (bank_rdata),
        .bank_wdata   (bank_wdata),
        .bank_we      (bank_we),
        .spi_tx_byte  (spi_tx_byte),
        .spi_tx_dv    (spi_tx_dv),
        .spi_tx_ready (spi_tx_ready),
        .spi_rx_dv    (spi_rx_dv),
        .spi_rx_byte  (spi_rx_byte),
        .busy         (busy)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // data bank: one-cycle read latency, write on strobe
    logic [7:0] mem [16];
    always @(posedge clk_in) begin
        bank_rdata <= mem[bank_addr];
        if (bank_we) mem[bank_addr] <= bank_wdata;
    end

    logic [7:0]  exp_tx   [$];
    logic [11:0] exp_wr   [$];
    logic [15:0] exp_ctrl [$];
    int tx_seen = 0, wr_seen = 0, ctrl_seen = 0;
    int cyc = 0, last_tx_cyc = 0, last_ctrl_cyc = 0;
    bit busy_chk = 1'b0;

    bit         rsp_en    = 1'b1;
    int         rsp_delay = 3;
    int         rsp_gap   = 0;
    logic [7:0] rsp_xor   = 8'h00;

    function automatic logic [15:0] ctrl_model(input logic [15:0] c, input logic err,
                                               input logic [3:0] nrx);
        logic [15:0] r;
        r       = c;
        r[0]    = 1'b0;
        r[3]    = err;
        r[11:8] = nrx;
        return r;
    endfunction

    // SPI master model: loops tx byte (xor mask) back after rsp_delay cycles
    initial begin
        logic [7:0] b;
        spi_tx_ready = 1'b1;
        spi_rx_dv    = 1'b0;
        spi_rx_byte  = '0;
        forever begin
            @(negedge clk_in);
            spi_rx_dv = 1'b0;
            if (spi_tx_dv && rsp_en) begin
                b = spi_tx_byte;
                spi_tx_ready = 1'b0;
                repeat (rsp_delay) @(negedge clk_in);
                spi_rx_byte = b ^ rsp_xor;
                spi_rx_dv   = 1'b1;
                if (rsp_gap > 0) begin
                    @(negedge clk_in);
                    spi_rx_dv = 1'b0;
                    repeat (rsp_gap - 1) @(negedge clk_in);
                end
                spi_tx_ready = 1'b1;
            end
        end
    end

    // monitor: compares DUT strobes against the scoreboard, models ctrl reg
    initial begin
        forever begin
            @(negedge clk_in);
            cyc++;
            if (busy_chk) begin
                chk("busy_drop", {31'd0, busy}, 32'd0);
                busy_chk = 1'b0;
            end
            if (spi_tx_dv) begin
                tx_seen++;
                last_tx_cyc = cyc;
                if (exp_tx.size() > 0) chk("tx_byte", {24'd0, spi_tx_byte}, {24'd0, exp_tx.pop_front()});
                else                   chk("tx_extra", {24'd0, spi_tx_byte}, 32'h1FF);
            end
            if (bank_we) begin
                wr_seen++;
                if (exp_wr.size() > 0) chk("bank_wr", {20'd0, bank_addr, bank_wdata}, {20'd0, exp_wr.pop_front()});
                else                   chk("bank_wr_extra", {20'd0, bank_addr, bank_wdata}, 32'h1FFF);
            end
            if (ctrl_we) begin
                ctrl_seen++;
                last_ctrl_cyc = cyc;
                chk("busy_at_ctrl_we", {31'd0, busy}, 32'd1);
                if (exp_ctrl.size() > 0) chk("ctrl_out", {16'd0, ctrl_out}, {16'd0, exp_ctrl.pop_front()});
                else                     chk("ctrl_extra", {16'd0, ctrl_out}, 32'h1FFFF);
                ctrl_in  = ctrl_out;
                busy_chk = 1'b1;
            end
        end
    end

    task automatic start_burst(input logic [15:0] c, input bit push_ctrl);
        int n;
        logic [7:0] b;
        n = int'(c[7:4]);
        for (int i = 0; i <= n; i++) begin
            b = c[1] ? 8'hFF : (c[2] ? 8'h00 : mem[i]);
            exp_tx.push_back(b);
            exp_wr.push_back({i[3:0], b ^ rsp_xor});
        end
        if (push_ctrl) exp_ctrl.push_back(ctrl_model(c, 1'b0, c[7:4]));
        ctrl_in = c;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk_in);
        while ((busy || exp_tx.size() > 0 || exp_wr.size() > 0 || exp_ctrl.size() > 0) && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        chk({tag, "_done"}, {31'd0, n < budget}, 32'd1);
        repeat (3) @(negedge clk_in);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tb, cb, wb, n;
        logic [7:0] ref_mem [16];
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);

        // reset values
        repeat (3) @(negedge clk_in);
        chk("rst_ctrl", {15'd0, ctrl_we, ctrl_out}, 32'd0);
        chk("rst_bank", {19'd0, bank_we, bank_addr, bank_wdata}, 32'd0);
        chk("rst_spi",  {22'd0, spi_tx_dv, spi_tx_byte, busy}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk_in);

        // single byte
        mem[0] = 8'h0A;
        cb = ctrl_seen; tb = tx_seen;
        start_burst(16'h0001, 1'b1);
        wait_idle("t1", 200);
        chk("t1_mem0", {24'd0, mem[0]}, 32'h0A);
        chk("t1_ntx", tx_seen - tb, 32'd1);
        chk("t1_nctrl", ctrl_seen - cb, 32'd1);

        // three bytes in order
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        tb = tx_seen; wb = wr_seen;
        start_burst(16'h0021, 1'b1);
        wait_idle("t2", 300);
        chk("t2_ntx", tx_seen - tb, 32'd3);
        chk("t2_nwr", wr_seen - wb, 32'd3);

        // all_ones
        start_burst(16'h0013, 1'b1);
        wait_idle("t3", 300);
        chk("t3_mem", {16'd0, mem[0], mem[1]}, 32'hFFFF);

        // both flags, ctrl rewritten mid-burst
        mem[0] = 8'h5C;
        cb = ctrl_seen; tb = tx_seen;
        rsp_delay = 6;
        start_burst(16'h0007, 1'b0);
        n = 0;
        while (tx_seen == tb && n < 100) begin @(negedge clk_in); n++; end
        chk("t4_tx_started", {31'd0, tx_seen > tb}, 32'd1);
        ctrl_in = 16'h0005;
        exp_ctrl.push_back(ctrl_model(16'h0005, 1'b0, 4'd0));
        wait_idle("t4", 300);
        repeat (10) @(negedge clk_in);
        chk("t4_nctrl", ctrl_seen - cb, 32'd1);
        chk("t4_ntx", tx_seen - tb, 32'd1);
        chk("t4_idle", {31'd0, busy}, 32'd0);

        // full 16-byte burst, xor'd loopback, ready held low between bytes,
        // pass-through of upper control bits
        rsp_xor = 8'h5A; rsp_delay = 2; rsp_gap = 6;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i] ^ 8'h5A;
        end
        start_burst(16'hA0F1, 1'b1);
        wait_idle("t5", 3000);
        n = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) n++;
        chk("t5_mem_errs", n, 32'd0);
        rsp_xor = 8'h00; rsp_gap = 0;

        // all_zeros, stale error and n_rx overwritten
        start_burst(16'h571D, 1'b0);
        exp_ctrl.push_back(16'h5114);
        wait_idle("t6", 300);

        // async reset during WAIT_RX of byte 1 of a 3-byte burst
        rsp_delay = 8;
        tb = tx_seen; cb = ctrl_seen; wb = wr_seen;
        start_burst(16'h0021, 1'b1);
        n = 0;
        while (tx_seen < tb + 2 && n < 200) begin @(negedge clk_in); n++; end
        chk("t7_byte1_sent", tx_seen - tb, 32'd2);
        repeat (2) @(negedge clk_in);
        #2;
        rst = 1'b0;
        #1;
        chk("t7_rst_ctrl", {15'd0, ctrl_we, ctrl_out}, 32'd0);
        chk("t7_rst_bank", {19'd0, bank_we, bank_addr, bank_wdata}, 32'd0);
        chk("t7_rst_spi",  {22'd0, spi_tx_dv, spi_tx_byte, busy}, 32'd0);
        exp_tx.delete(); exp_wr.delete(); exp_ctrl.delete();
        ctrl_in = 16'h0000;
        repeat (3) @(negedge clk_in);
        rst = 1'b1;
        repeat (20) @(negedge clk_in);
        chk("t7_idle", {31'd0, busy}, 32'd0);
        chk("t7_nwr", wr_seen - wb, 32'd1);
        chk("t7_nctrl", ctrl_seen - cb, 32'd0);
        rsp_delay = 3;

`ifdef SPI_SEQ_TIMEOUT_EN
        // no response: abort after TIMEOUT cycles in WAIT_RX
        rsp_en = 1'b0;
        mem[0] = 8'h3C;
        wb = wr_seen;
        exp_tx.push_back(8'h3C);
        exp_ctrl.push_back(ctrl_model(16'h0001, 1'b1, 4'd0));
        ctrl_in = 16'h0001;
        wait_idle("t8", 300);
        chk("t8_latency", last_ctrl_cyc - last_tx_cyc, 32'd20);
        chk("t8_nwr", wr_seen - wb, 32'd0);
        rsp_en = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
